// File: rtl/viterbi_out_packer.sv
// viterbi_out_packer: drops the first SKIP_N decoded bits after reset or flush,
// packs the remaining bits into bytes and queues them in a small byte FIFO that
// drains over a valid/ready interface. A flush pads and emits any partial byte
// marked as last, then re-arms the warm-up skip.
// Optional build macro: VITERBI_PACKER_LSB_FIRST_EN packs the first bit of each
// byte into data[0] instead of data[7].
module viterbi_out_packer #(
  parameter int SKIP_N     = 61,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               bit_valid_i,
  input  logic                               bit_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [7:0]                         data_o,
  output logic                               last_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_o,
  output logic                               overflow_o
);

  localparam int SKIP_W = (SKIP_N > 0) ? $clog2(SKIP_N + 1) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ST_SKIP, ST_PACK} state_t;

  // With no warm-up bits the skip phase is bypassed entirely.
  localparam state_t ARM_STATE = (SKIP_N == 0) ? ST_PACK : ST_SKIP;

  state_t            state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_inc;
  logic              skip_done;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_pos;
  logic [7:0]        shift_reg;
  logic [7:0]        pack_byte;
  logic              pack_bit;
  logic              byte_done;
  logic              push;
  logic              pop;
  logic              full;
  logic              drop;
  logic              write;
  logic              overflow;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  assign skip_inc  = skip_cnt + SKIP_W'(1);
  assign skip_done = (skip_inc == SKIP_W'(SKIP_N));
  assign pack_bit  = bit_valid_i && (state == ST_PACK);
  assign byte_done = pack_bit && (bit_cnt == 3'd7);

`ifdef VITERBI_PACKER_LSB_FIRST_EN
  assign bit_pos = bit_cnt;
`else
  assign bit_pos = 3'd7 - bit_cnt;
`endif

  // Byte under construction including this cycle's bit; unfilled positions stay zero,
  // which doubles as the flush padding.
  always_comb begin
    pack_byte = shift_reg;
    if (pack_bit) pack_byte[bit_pos] = bit_i;
  end

  assign push  = byte_done || (flush_i && (state == ST_PACK) && (pack_bit || (bit_cnt != 3'd0)));
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign pop   = valid_o && ready_i;
  assign drop  = push && full && !pop;
  assign write = push && !drop;

  // Skip/pack sequencing: counts warm-up bits, then assembles bytes; flush re-arms.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ARM_STATE;
      skip_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (flush_i) begin
      state     <= ARM_STATE;
      skip_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (bit_valid_i) begin
      case (state)
        ST_SKIP: begin
          if (skip_done) begin
            state    <= ST_PACK;
            skip_cnt <= '0;
          end else begin
            skip_cnt <= skip_inc;
          end
        end
        ST_PACK: begin
          bit_cnt   <= bit_cnt + 3'd1;
          shift_reg <= byte_done ? 8'h00 : pack_byte;
        end
        default: state <= ARM_STATE;
      endcase
    end
  end

  // FIFO storage; contents are qualified by level, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (write) mem[wr_ptr] <= {flush_i, pack_byte};
  end

  // FIFO pointers, occupancy and the sticky overflow flag (a drop beats a flush clear).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (write && !pop)      level <= level + LVL_W'(1);
      else if (pop && !write) level <= level - LVL_W'(1);
      if (flush_i)   overflow <= drop;
      else if (drop) overflow <= 1'b1;
    end
  end

  assign valid_o    = (level != '0);
  assign data_o     = valid_o ? mem[rd_ptr][7:0] : 8'h00;
  assign last_o     = valid_o ? mem[rd_ptr][8] : 1'b0;
  assign level_o    = level;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_viterbi_out_packer.sv
// Self-checking bench for viterbi_out_packer: directed sequences, a vector table and
// a randomized run, all compared against a queue-based reference model.
module tb_viterbi_out_packer;

  localparam int SKIP_N = 61;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       bit_valid;
  logic       bit_in;
  logic       ready;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic [2:0] level;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: warm-up bits left, bits of the partial byte, byte queue.
  int         skip_left;
  bit         partial[$];
  logic [8:0] mfifo[$];
  bit         movf;

  typedef struct {
    logic       f;
    logic       bv;
    logic       b;
    logic       r;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_last;
    logic [2:0] exp_level;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  viterbi_out_packer #(.SKIP_N(SKIP_N), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bit_valid_i(bit_valid), .bit_i(bit_in),
    .valid_o(valid), .ready_i(ready), .data_o(data), .last_o(last), .level_o(level),
    .overflow_o(overflow)
  );

  // Bit i (in arrival order) of a byte that should pack to value v.
  function automatic logic pbit(input logic [7:0] v, input int i);
`ifdef VITERBI_PACKER_LSB_FIRST_EN
    return v[i];
`else
    return v[7-i];
`endif
  endfunction

  function automatic logic [7:0] form_byte();
    logic [7:0] b = 8'h00;
    for (int i = 0; i < partial.size(); i++) begin
`ifdef VITERBI_PACKER_LSB_FIRST_EN
      b[i] = partial[i];
`else
      b[7-i] = partial[i];
`endif
    end
    return b;
  endfunction

  task automatic model_reset();
    skip_left = SKIP_N;
    partial.delete();
    mfifo.delete();
    movf = 1'b0;
  endtask

  task automatic model_step(input logic f, input logic bv, input logic b, input logic r);
    logic [7:0] byt = 8'h00;
    bit done = 1'b0;
    bit dropped = 1'b0;
    if (r && mfifo.size() > 0) void'(mfifo.pop_front());
    if (bv) begin
      if (skip_left > 0) skip_left--;
      else partial.push_back(b);
    end
    if (partial.size() == 8 || (f && partial.size() > 0)) begin
      byt = form_byte();
      done = 1'b1;
      partial.delete();
    end
    if (done) begin
      if (mfifo.size() < DEPTH) mfifo.push_back({f, byt});
      else dropped = 1'b1;
    end
    if (f) begin
      skip_left = SKIP_N;
      partial.delete();
      movf = dropped;
    end else if (dropped) begin
      movf = 1'b1;
    end
  endtask

  task automatic expect_val(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    logic       ev = (mfifo.size() != 0);
    logic [7:0] ed = ev ? mfifo[0][7:0] : 8'h00;
    logic       el = ev ? mfifo[0][8] : 1'b0;
    logic [2:0] elev = 3'(mfifo.size());
    tests_run++;
    if ({valid, data, last, level, overflow} !== {ev, ed, el, elev, movf}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got v=%b d=%h l=%b lvl=%0d ovf=%b, expected v=%b d=%h l=%b lvl=%0d ovf=%b",
               name, valid, data, last, level, overflow, ev, ed, el, elev, movf);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic bv, input logic b, input logic r,
                               input string name);
    flush = f; bit_valid = bv; bit_in = b; ready = r;
    @(posedge clk);
    model_step(f, bv, b, r);
    #1;
    checkOutput(name);
  endtask

  task automatic send_value(input logic [7:0] v, input int nbits, input logic r, input string name);
    for (int i = 0; i < nbits; i++) applyStimulus(1'b0, 1'b1, pbit(v, i), r, name);
  endtask

  task automatic do_reset(input string name);
    flush = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; ready = 1'b0;
    rst_n = 1'b0;
    #1;
    expect_val({name, "_valid"}, valid, 0);
    expect_val({name, "_data"}, data, 0);
    expect_val({name, "_last"}, last, 0);
    expect_val({name, "_level"}, level, 0);
    expect_val({name, "_ovf"}, overflow, 0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat = 8'b10110010;
    logic [7:0] exp1;
    logic [7:0] exp3;
    logic [7:0] exp4;
    logic       f, bv, b, r;

`ifdef VITERBI_PACKER_LSB_FIRST_EN
    exp1 = 8'h4D; exp3 = 8'h05; exp4 = 8'h8F;
`else
    exp1 = 8'hB2; exp3 = 8'hA0; exp4 = 8'hF1;
`endif

    // Vector table: seven bits, then the 8th bit together with flush, then drain.
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp4, 1'b1, 3'd1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp4, 1'b1, 3'd1};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};

    do_reset("reset");

    // Warm-up skip then one byte; it must appear exactly after the 69th bit.
    for (int i = 0; i < SKIP_N; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "t1_skip");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, pat[7-i], 1'b1, "t1_pack");
      if (i == 6) expect_val("t1_valid_early", valid, 0);
    end
    expect_val("t1_valid", valid, 1);
    expect_val("t1_data", data, exp1);
    expect_val("t1_last", last, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t1_pop");

    // Five bytes into a stalled FIFO: fourth fills it, fifth is dropped.
    for (int k = 1; k <= 5; k++) send_value(8'(k), 8, 1'b0, "t2_fill");
    expect_val("t2_level_full", level, 4);
    expect_val("t2_overflow", overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      expect_val("t2_drain_data", data, k);
      expect_val("t2_drain_level", level, 5 - k);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t2_drain");
    end
    expect_val("t2_level_empty", level, 0);

    // Partial byte flushed, then the skip is re-armed.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "t3_bits");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t3_bits");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "t3_bits");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t3_flush");
    expect_val("t3_data", data, exp3);
    expect_val("t3_last", last, 1);
    expect_val("t3_ovf_cleared", overflow, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t3_pop");
    for (int i = 0; i < SKIP_N; i++)
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, "t3_reskip");
    expect_val("t3_no_output", level, 0);
    send_value(8'h3C, 8, 1'b0, "t3_repack");
    expect_val("t3_repack_data", data, 8'h3C);
    expect_val("t3_repack_last", last, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t3_pop2");

    // Table: 8th bit arriving with flush yields a single last byte.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].f, tbl[i].bv, tbl[i].b, tbl[i].r, "t4_model");
      expect_val("t4_valid", valid, tbl[i].exp_valid);
      expect_val("t4_data", data, tbl[i].exp_data);
      expect_val("t4_last", last, tbl[i].exp_last);
      expect_val("t4_level", level, tbl[i].exp_level);
    end

    // Push and pop in the same cycle while full.
    for (int i = 0; i < SKIP_N; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t5_skip");
    for (int k = 1; k <= 4; k++) send_value(8'(k * 16), 8, 1'b0, "t5_fill");
    send_value(8'h50, 7, 1'b0, "t5_partial");
    applyStimulus(1'b0, 1'b1, pbit(8'h50, 7), 1'b1, "t5_pushpop");
    expect_val("t5_level", level, 4);
    expect_val("t5_ovf", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      expect_val("t5_order", data, k * 16);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t5_drain");
    end

    // Asynchronous reset mid-byte with a byte queued; skip must be re-armed.
    send_value(8'h77, 8, 1'b0, "t6_byte");
    send_value(8'h0F, 3, 1'b0, "t6_partial");
    do_reset("t6_reset");
    for (int i = 0; i < SKIP_N; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "t6_skip");
    expect_val("t6_skip_empty", level, 0);
    send_value(8'hC3, 8, 1'b0, "t6_pack");
    expect_val("t6_data", data, 8'hC3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t6_pop");

    // Randomized traffic against the model.
    do_reset("rand_reset");
    for (int n = 0; n < 4000; n++) begin
      f  = ($urandom_range(0, 149) == 0);
      bv = ($urandom_range(0, 9) < 8);
      b  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 3) == 0);
      applyStimulus(f, bv, b, r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
